// File: rtl/mac_operand_sign_block_pkg.sv
// mac_operand_sign_block_pkg: lane-mode and cfg field encodings shared by the MAC front end and negator
package mac_operand_sign_block_pkg;
  typedef enum logic [1:0] {LM_SINGLE = 2'b00, LM_DUAL = 2'b01, LM_QUAD = 2'b10} lane_mode_e;
  localparam int CFG_SIGNED = 3;
  localparam int CFG_MAC = 2;
  function automatic lane_mode_e decode_mode(input logic [1:0] m);
    return m == 2'b10 ? LM_QUAD : m == 2'b01 ? LM_DUAL : LM_SINGLE;
  endfunction
endpackage

// File: rtl/n_bit_cla_adder.sv
// n_bit_cla_adder: N-bit carry-lookahead adder with carry in/out
module n_bit_cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);
  logic [N-1:0] g, p;
  logic [N:0] c;
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    c[0] = c_i;
    for (int k = 0; k < N; k++) c[k+1] = g[k] | (p[k] & c[k]);
  end
  assign s_o = p ^ c[N-1:0];
  assign c_o = c[N];
endmodule

// File: rtl/mac_operand_sign_block.sv
// mac_operand_sign_block: signed operands to per-lane magnitudes plus negative-product flags, 2-entry skid queue
module mac_operand_sign_block
  import mac_operand_sign_block_pkg::*;
#(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_OP_WIDTH   = 4*MAC_MIN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic [MAC_OP_WIDTH-1:0]   A_in,
  input  logic [MAC_OP_WIDTH-1:0]   B_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [MAC_OP_WIDTH-1:0]   A_mag,
  output logic [MAC_OP_WIDTH-1:0]   B_mag,
  output logic                      C0_neg,
  output logic                      C1_neg,
  output logic                      C2_neg,
  output logic                      C3_neg,
  output logic [MAC_CONF_WIDTH-1:0] cfg_out,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int L = MAC_MIN_WIDTH;
  localparam int W = 2*MAC_OP_WIDTH + 4 + MAC_CONF_WIDTH;
  lane_mode_e mode;
  logic [3:1] link;
  logic [3:0] negs;
  logic [MAC_OP_WIDTH-1:0] a_m, b_m;
  assign mode = decode_mode(cfg[1:0]);
  assign link = {mode != LM_SINGLE, mode == LM_QUAD, mode != LM_SINGLE};
  // every lane always computes ~x + cin; the carry chain makes a multi-lane segment a full two's complement
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic ca, cb, coa, cob, sa, sb;
    logic [L-1:0] xa, xb, na, nb;
    assign xa = A_in[i*L +: L];
    assign xb = B_in[i*L +: L];
    if (i == 0) begin : g_head
      assign ca = 1'b1;
      assign cb = 1'b1;
    end else begin : g_link
      assign ca = link[i] ? g_lane[i-1].coa : 1'b1;
      assign cb = link[i] ? g_lane[i-1].cob : 1'b1;
    end
    n_bit_cla_adder #(.N(L)) u_a (.a_i(~xa), .b_i('0), .c_i(ca), .s_o(na), .c_o(coa));
    n_bit_cla_adder #(.N(L)) u_b (.a_i(~xb), .b_i('0), .c_i(cb), .s_o(nb), .c_o(cob));
    assign sa = mode == LM_QUAD ? A_in[MAC_OP_WIDTH-1] : mode == LM_DUAL ? A_in[(i/2)*2*L+2*L-1] : A_in[i*L+L-1];
    assign sb = mode == LM_QUAD ? B_in[MAC_OP_WIDTH-1] : mode == LM_DUAL ? B_in[(i/2)*2*L+2*L-1] : B_in[i*L+L-1];
    assign a_m[i*L +: L] = cfg[CFG_SIGNED] & sa ? na : xa;
    assign b_m[i*L +: L] = cfg[CFG_SIGNED] & sb ? nb : xb;
    assign negs[i] = cfg[CFG_SIGNED] & (mode == LM_SINGLE | i == 3 | (mode == LM_DUAL & i == 1)) & (sa ^ sb);
  end
  logic [W-1:0] mem_q [2];
  logic wp_q, rp_q, push, pop;
  logic [1:0] cnt_q, cnt_d;
  assign in_ready = cnt_q != 2'd2 & ~rst;
  assign out_valid = cnt_q != 2'd0;
  assign push = en & in_valid & in_ready;
  assign pop = en & out_valid & out_ready;
  assign cnt_d = cnt_q + 2'(push) - 2'(pop);
  assign {A_mag, B_mag, C3_neg, C2_neg, C1_neg, C0_neg, cfg_out} = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wp_q] <= {a_m, b_m, negs, cfg};
      wp_q <= wp_q ^ push;
      rp_q <= rp_q ^ pop;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mac_operand_sign_block.sv
// tb_mac_operand_sign_block: directed vectors with a scoreboard queue and an independent output monitor
module tb_mac_operand_sign_block;
  logic clk = 1'b0;
  logic rst, en, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] cfg, cfg_out;
  logic [31:0] A_in, B_in, A_mag, B_mag;
  logic C0_neg, C1_neg, C2_neg, C3_neg;
  logic [71:0] outv;
  logic [71:0] sb [$];
  int checks = 0;
  int errors = 0;
  int tries;
  always #5 clk = ~clk;
  mac_operand_sign_block dut (
    .clk(clk), .rst(rst), .en(en), .cfg(cfg), .A_in(A_in), .B_in(B_in),
    .in_valid(in_valid), .in_ready(in_ready), .A_mag(A_mag), .B_mag(B_mag),
    .C0_neg(C0_neg), .C1_neg(C1_neg), .C2_neg(C2_neg), .C3_neg(C3_neg),
    .cfg_out(cfg_out), .out_valid(out_valid), .out_ready(out_ready)
  );
  assign outv = {A_mag, B_mag, C3_neg, C2_neg, C1_neg, C0_neg, cfg_out};
  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] en_exp,
                      output int t_out);
    bit acc = 1'b0;
    cfg = c; A_in = a; B_in = b; in_valid = 1'b1;
    t_out = 0;
    while (!acc && t_out < 20) begin
      @(negedge clk);
      t_out++;
      if (in_ready && en) begin
        sb.push_back({ea, eb, en_exp, c});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat A=%h not accepted within 20 cycles", a);
    end
  endtask
  task automatic drain();
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain", 72'(sb.size()), 72'd0);
  endtask
  // pops one expected beat for every handshake the DUT will complete at the next edge
  always @(negedge clk) begin
    if (!rst && en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: unexpected output %h expected none", outv);
      end else chk("beat", outv, sb.pop_front());
    end
  end
  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cfg = '0; A_in = '0; B_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 72'(in_ready), 72'd0);
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_outputs", outv, 72'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1;
    send(4'b1000, 32'h017F80FB, 32'h8002FF03, 32'h017F8005, 32'h80020103, 4'b1001, tries);
    @(negedge clk);
    chk("latency", 72'(out_valid), 72'd1);
    @(posedge clk); #1;
    send(4'b1001, 32'h0005FF00, 32'hFFFB0002, 32'h00050100, 32'h00050002, 4'b1010, tries);
    send(4'b1001, 32'h80008000, 32'h00010001, 32'h80008000, 32'h00010001, 4'b1010, tries);
    send(4'b1010, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h80000000, 4'b0000, tries);
    send(4'b1010, 32'h00000003, 32'h80000000, 32'h00000003, 32'h80000000, 4'b1000, tries);
    send(4'b1011, 32'h81FE0201, 32'h01010101, 32'h7F020201, 32'h01010101, 4'b1100, tries);
    send(4'b0000, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 4'b0000, tries);
    drain();
    out_ready = 1'b0;
    send(4'b1000, 32'h000000FF, 32'h00000001, 32'h00000001, 32'h00000001, 4'b0001, tries);
    send(4'b1001, 32'hFFFF0000, 32'h00000001, 32'h00010000, 32'h00000001, 4'b1000, tries);
    cfg = 4'b0100; A_in = 32'h80808080; B_in = 32'h7F7F7F7F; in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", 72'(in_ready), 72'd0);
    chk("full_out_valid", 72'(out_valid), 72'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(4'b0100, 32'h80808080, 32'h7F7F7F7F, 32'h80808080, 32'h7F7F7F7F, 4'b0000, tries);
    chk("third_after_pop", 72'(tries), 72'd2);
    drain();
    out_ready = 1'b0;
    send(4'b1010, 32'hFFFFFFFE, 32'h00000005, 32'h00000002, 32'h00000005, 4'b1000, tries);
    send(4'b1000, 32'h000000FB, 32'h00000000, 32'h00000005, 32'h00000000, 4'b0001, tries);
    en = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 72'(out_valid), 72'd1);
      chk("stall_hold", outv, {32'h00000002, 32'h00000005, 4'b1000, 4'b1010});
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_valid", 72'(out_valid), 72'd0);
    chk("rst_mid_outputs", outv, 72'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(4'b1001, 32'h7FFF8001, 32'hFFFF0001, 32'h7FFF7FFF, 32'h00010001, 4'b1010, tries);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
